// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer driving PC control pins and an instruction register
module fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 16'h0
) (
    input  logic                  clock,
    input  logic                  notReset,
    output logic                  pc_notOE,
    output logic                  pc_notLoad,
    output logic                  pc_inc,
    output logic [DATA_WIDTH-1:0] pc_load_data,
    output logic                  mem_notRead,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  jump_req,
    input  logic [DATA_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    input  logic                  ir_accept
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ADDR,
        S_WAIT,
        S_FULL,
        S_IDLE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    jump_pend;
    logic [DATA_WIDTH-1:0]   jtarget;
    logic                    ir_load;
    logic                    valid_set;
    logic                    valid_clr;
    logic                    pend_clr;

    // State register; reset restarts the sequence with a load of the reset vector
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the single-cycle action strobes of each state
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        valid_set = 1'b0;
        valid_clr = 1'b0;
        pend_clr  = 1'b0;
        case (state)
            S_LOAD: begin
                pend_clr  = 1'b1;
                state_nxt = halt ? S_IDLE : S_ADDR;
            end
            S_ADDR: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    if (jump_pend || jump_req) begin
                        // Word belongs to the abandoned stream: drop it and redirect
                        state_nxt = S_LOAD;
                    end else begin
                        ir_load   = 1'b1;
                        valid_set = 1'b1;
                        state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (jump_req || jump_pend) begin
                    valid_clr = 1'b1;
                    state_nxt = S_LOAD;
                end else if (ir_accept) begin
                    valid_clr = 1'b1;
                    state_nxt = halt ? S_IDLE : S_ADDR;
                end
            end
            S_IDLE: begin
                if (jump_pend) begin
                    state_nxt = S_LOAD;
                end else if (!halt) begin
                    state_nxt = S_ADDR;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // Instruction register and its valid flag
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (ir_load) begin
                ir <= mem_data;
            end
            if (valid_set) begin
                ir_valid <= 1'b1;
            end else if (valid_clr) begin
                ir_valid <= 1'b0;
            end
        end
    end

    // Jump capture in any state; a new request wins over the clear done by S_LOAD
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            jump_pend <= 1'b0;
            jtarget   <= RESET_VECTOR;
        end else if (jump_req) begin
            jump_pend <= 1'b1;
            jtarget   <= jump_addr;
        end else if (pend_clr) begin
            jump_pend <= 1'b0;
        end
    end

    assign pc_notLoad   = (state != S_LOAD);
    assign pc_notOE     = !((state == S_ADDR) || (state == S_WAIT));
    assign mem_notRead  = !((state == S_ADDR) || (state == S_WAIT));
    assign pc_inc       = ir_load;
    assign pc_load_data = jtarget;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int          DW = 16;
    localparam logic [15:0] RV = 16'h0100;

    logic          clock = 1'b0;
    logic          notReset = 1'b0;
    logic          pc_notOE;
    logic          pc_notLoad;
    logic          pc_inc;
    logic [DW-1:0] pc_load_data;
    logic          mem_notRead;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic          jump_req = 1'b0;
    logic [DW-1:0] jump_addr = '0;
    logic          halt = 1'b0;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic          ir_accept = 1'b0;

    fetch_sequencer #(.DATA_WIDTH(DW), .RESET_VECTOR(RV)) dut (
        .clock(clock),
        .notReset(notReset),
        .pc_notOE(pc_notOE),
        .pc_notLoad(pc_notLoad),
        .pc_inc(pc_inc),
        .pc_load_data(pc_load_data),
        .mem_notRead(mem_notRead),
        .mem_ready(mem_ready),
        .mem_data(mem_data),
        .jump_req(jump_req),
        .jump_addr(jump_addr),
        .halt(halt),
        .ir(ir),
        .ir_valid(ir_valid),
        .ir_accept(ir_accept)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wait_states = 0;
    int          mem_cnt = 0;
    logic [15:0] pc_model = '0;
    logic [15:0] exp_ir = '0;
    logic [15:0] exp_target = RV;
    bit          jump_out = 0;
    bit          prev_valid = 0;
    int          n_inc = 0;
    int          n_load = 0;
    int          n_valid = 0;
    int          cyc;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h0100) ? 16'hA5A5 : a + 16'h1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers the address held by the PC after wait_states stall cycles
    initial begin
        forever begin
            @(negedge clock);
            if (!notReset || mem_notRead) begin
                mem_cnt   = 0;
                mem_ready = 1'b0;
            end else begin
                if (mem_cnt >= wait_states + 1) begin
                    mem_ready = 1'b1;
                    mem_data  = mem_fn(pc_model);
                end else begin
                    mem_ready = 1'b0;
                end
                mem_cnt++;
            end
        end
    end

    // Transaction-level model: external PC, last jump target, expected IR word
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!notReset) begin
                exp_target = RV;
                jump_out   = 0;
                prev_valid = 0;
            end else begin
                chk("oe_vs_read", pc_notOE, mem_notRead);
                if (!pc_notLoad) begin
                    chk("load_oe", pc_notOE, 1);
                    chk("load_inc", pc_inc, 0);
                    chk("load_data", pc_load_data, exp_target);
                    n_load++;
                    jump_out = 0;
                end
                if (pc_inc) begin
                    chk("inc_ready", mem_ready, 1);
                    chk("inc_no_jump", jump_out || jump_req, 0);
                    exp_ir = mem_fn(pc_model);
                    n_inc++;
                end
                if (ir_valid) begin
                    chk("ir_word", ir, exp_ir);
                    chk("valid_no_read", mem_notRead, 1);
                    chk("valid_no_jump", jump_out, 0);
                    if (!prev_valid) n_valid++;
                end
                if (!pc_notLoad) pc_model = pc_load_data;
                else if (pc_inc) pc_model = pc_model + 16'h1;
                if (jump_req) begin
                    exp_target = jump_addr;
                    jump_out   = 1;
                end
                prev_valid = ir_valid;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        notReset  = 1'b0;
        jump_req  = 1'b0;
        ir_accept = 1'b0;
        halt      = 1'b0;
        @(negedge clock);
        n_inc   = 0;
        n_load  = 0;
        n_valid = 0;
        @(negedge clock);
        notReset = 1'b1;
        #3;
    endtask

    task automatic wait_rise(input string name, input int max, output int cnt);
        bit got;
        bit was;
        got = 0;
        was = ir_valid;
        cnt = 0;
        while (!got && cnt < max) begin
            @(negedge clock);
            #3;
            cnt++;
            got = ir_valid && !was;
            was = ir_valid;
        end
        chk(name, got, 1);
    endtask

    initial begin
        // 1: reset state and first fetch with zero wait states
        wait_states = 0;
        repeat (2) @(negedge clock);
        #3;
        chk("rst_ir", ir, 16'h0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_read", mem_notRead, 1);
        chk("rst_oe", pc_notOE, 1);
        chk("rst_inc", pc_inc, 0);
        @(negedge clock);
        notReset = 1'b1;
        #3;
        chk("t1_load", pc_notLoad, 0);
        chk("t1_load_data", pc_load_data, 16'h0100);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            #3;
            if (k < 3) chk("t1_early_valid", ir_valid, 0);
        end
        chk("t1_valid", ir_valid, 1);
        chk("t1_ir", ir, 16'hA5A5);
        chk("t1_inc_count", n_inc, 1);
        chk("t1_pc", pc_model, 16'h0101);

        // 2: two wait states, decoder always accepting, four fetches
        wait_states = 2;
        do_reset();
        ir_accept = 1'b1;
        wait_rise("t2_rise1", 20, cyc);
        chk("t2_first_latency", cyc, 5);
        for (int i = 2; i <= 4; i++) begin
            wait_rise("t2_rise", 20, cyc);
            chk("t2_period", cyc, 5);
        end
        chk("t2_valid_count", n_valid, 4);
        chk("t2_inc_count", n_inc, 4);
        chk("t2_pc", pc_model, 16'h0104);
        chk("t2_ir", ir, 16'h1337);

        // 3: jump during S_WAIT discards the word in flight
        do_reset();
        @(negedge clock);
        @(negedge clock);
        jump_req  = 1'b1;
        jump_addr = 16'h2000;
        #3;
        chk("t3_in_wait", mem_notRead, 0);
        @(negedge clock);
        jump_req = 1'b0;
        #3;
        for (int i = 0; i < 10 && pc_notLoad; i++) begin
            @(negedge clock);
            #3;
        end
        chk("t3_reload", pc_notLoad, 0);
        chk("t3_reload_data", pc_load_data, 16'h2000);
        chk("t3_no_inc", n_inc, 0);
        chk("t3_no_valid", ir_valid, 0);
        wait_rise("t3_rise", 20, cyc);
        chk("t3_latency", cyc, 5);
        chk("t3_ir", ir, 16'h3234);
        chk("t3_pc", pc_model, 16'h2001);

        // 4: jump in S_FULL with accept in the same cycle
        @(negedge clock);
        jump_req  = 1'b1;
        jump_addr = 16'h4000;
        ir_accept = 1'b1;
        #3;
        chk("t4_full", ir_valid, 1);
        @(negedge clock);
        jump_req  = 1'b0;
        ir_accept = 1'b0;
        #3;
        chk("t4_dropped", ir_valid, 0);
        chk("t4_load", pc_notLoad, 0);
        chk("t4_load_data", pc_load_data, 16'h4000);
        chk("t4_no_read", mem_notRead, 1);
        wait_rise("t4_rise", 20, cyc);
        chk("t4_ir", ir, 16'h5234);
        chk("t4_pc", pc_model, 16'h4001);

        // 5: halt raised in S_WAIT lets the fetch finish, then idles
        do_reset();
        @(negedge clock);
        @(negedge clock);
        halt = 1'b1;
        #3;
        chk("t5_in_wait", mem_notRead, 0);
        wait_rise("t5_rise", 20, cyc);
        chk("t5_ir", ir, 16'hA5A5);
        @(negedge clock);
        ir_accept = 1'b1;
        #3;
        @(negedge clock);
        ir_accept = 1'b0;
        #3;
        chk("t5_consumed", ir_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #3;
            chk("t5_idle_read", mem_notRead, 1);
            chk("t5_idle_load", pc_notLoad, 1);
        end
        @(negedge clock);
        halt = 1'b0;
        #3;
        wait_rise("t5_resume", 20, cyc);
        chk("t5_resume_ir", ir, 16'h1335);
        chk("t5_load_count", n_load, 1);
        chk("t5_pc", pc_model, 16'h0102);

        // 6: asynchronous reset in the middle of S_WAIT
        do_reset();
        @(negedge clock);
        @(negedge clock);
        #3;
        chk("t6_in_wait", mem_notRead, 0);
        @(negedge clock);
        #1;
        notReset = 1'b0;
        #1;
        chk("t6_async_read", mem_notRead, 1);
        chk("t6_async_oe", pc_notOE, 1);
        chk("t6_async_valid", ir_valid, 0);
        @(negedge clock);
        notReset = 1'b1;
        #3;
        chk("t6_restart_load", pc_notLoad, 0);
        chk("t6_restart_data", pc_load_data, 16'h0100);
        wait_rise("t6_rise", 20, cyc);
        chk("t6_latency", cyc, 5);
        chk("t6_ir", ir, 16'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
